// File: rtl/smi_mem_lib_read_burst_single64_if.sv
// Handshake bundle for the single-burst SMI read engine: params in, read data out,
// done status out, plus the SMI request/response link pair.
interface smi_mem_lib_read_burst_single64_if;
    logic        paramsValid;
    logic [63:0] paramBurstAddr;
    logic [15:0] paramBurstLen;
    logic [7:0]  paramBurstOpts;
    logic        paramsStop;

    logic        readValid;
    logic [63:0] readData;
    logic        readStop;

    logic        doneValid;
    logic        doneStatusOk;
    logic        doneStop;

    logic        smiReqValid;
    logic [7:0]  smiReqEofc;
    logic [63:0] smiReqData;
    logic        smiReqStop;

    logic        smiRespValid;
    logic [7:0]  smiRespEofc;
    logic [63:0] smiRespData;
    logic        smiRespStop;

    // slave: the burst engine itself
    modport slave (
        input  paramsValid, paramBurstAddr, paramBurstLen, paramBurstOpts,
        output paramsStop,
        output readValid, readData,
        input  readStop,
        output doneValid, doneStatusOk,
        input  doneStop,
        output smiReqValid, smiReqEofc, smiReqData,
        input  smiReqStop,
        input  smiRespValid, smiRespEofc, smiRespData,
        output smiRespStop
    );

    // master: whatever drives params and sinks data/done, plus the SMI fabric
    modport master (
        output paramsValid, paramBurstAddr, paramBurstLen, paramBurstOpts,
        input  paramsStop,
        input  readValid, readData,
        output readStop,
        input  doneValid, doneStatusOk,
        output doneStop,
        input  smiReqValid, smiReqEofc, smiReqData,
        output smiReqStop,
        output smiRespValid, smiRespEofc, smiRespData,
        input  smiRespStop
    );
endinterface

// File: rtl/smi_mem_lib_read_burst_single64.sv
// Single 64-bit SMI read burst: sends a two-flit read request, streams response data
// straight through to the read port, drains any excess, then reports a status word.
module smi_mem_lib_read_burst_single64 (
    input  logic clk,
    input  logic srst,
    smi_mem_lib_read_burst_single64_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, REQ_HDR, REQ_ADDR, RESP_HDR, RESP_DATA, RESP_DRAIN, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] addr;
    logic [12:0] len;
    logic [7:0]  opts;
    logic [12:0] count, count_nxt;
    logic        status_ok, status_nxt;
    logic        capture;
    logic [15:0] byte_len;

    assign byte_len = {len, 3'b000};

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state     <= IDLE;
            count     <= '0;
            status_ok <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            status_ok <= status_nxt;
        end
    end

    // Burst parameters are only meaningful after capture, so they carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            addr <= {bus.paramBurstAddr[63:3], 3'b000};
            len  <= bus.paramBurstLen[12:0];
            opts <= bus.paramBurstOpts;
        end
    end

    always_comb begin
        state_nxt        = state;
        count_nxt        = count;
        status_nxt       = status_ok;
        capture          = 1'b0;
        bus.paramsStop   = 1'b1;
        bus.readValid    = 1'b0;
        bus.readData     = bus.smiRespData;
        bus.doneValid    = 1'b0;
        bus.doneStatusOk = 1'b0;
        bus.smiReqValid  = 1'b0;
        bus.smiReqEofc   = 8'd0;
        bus.smiReqData   = 64'd0;
        bus.smiRespStop  = 1'b1;

        case (state)
            IDLE: begin
                bus.paramsStop = 1'b0;
                if (bus.paramsValid) begin
                    capture    = 1'b1;
                    status_nxt = 1'b0;
                    // Zero or oversize bursts finish immediately without touching SMI.
                    if (bus.paramBurstLen[12:0] == 13'd0 || bus.paramBurstLen > 16'd512)
                        state_nxt = DONE;
                    else
                        state_nxt = REQ_HDR;
                end
            end
            REQ_HDR: begin
                bus.smiReqValid = 1'b1;
                bus.smiReqData  = {24'd0, opts, byte_len, 8'd0, 8'h02};
                if (!bus.smiReqStop) state_nxt = REQ_ADDR;
            end
            REQ_ADDR: begin
                bus.smiReqValid = 1'b1;
                bus.smiReqEofc  = 8'd8;
                bus.smiReqData  = addr;
                if (!bus.smiReqStop) state_nxt = RESP_HDR;
            end
            RESP_HDR: begin
                bus.smiRespStop = 1'b0;
                if (bus.smiRespValid) begin
                    if (bus.smiRespEofc != 8'd0) begin
                        status_nxt = 1'b0;
                        state_nxt  = DONE;
                    end else begin
                        status_nxt = (bus.smiRespData[15:8] == 8'd0);
                        count_nxt  = len;
                        state_nxt  = RESP_DATA;
                    end
                end
            end
            RESP_DATA: begin
                bus.readValid   = bus.smiRespValid;
                bus.smiRespStop = bus.readStop;
                if (bus.smiRespValid && !bus.readStop) begin
                    count_nxt = count - 13'd1;
                    if (count == 13'd1) begin
                        // Final expected word: any flits beyond it mean an overlong response.
                        if (bus.smiRespEofc != 8'd0) begin
                            state_nxt = DONE;
                        end else begin
                            status_nxt = 1'b0;
                            state_nxt  = RESP_DRAIN;
                        end
                    end else if (bus.smiRespEofc != 8'd0) begin
                        status_nxt = 1'b0;
                        state_nxt  = DONE;
                    end
                end
            end
            RESP_DRAIN: begin
                bus.smiRespStop = 1'b0;
                if (bus.smiRespValid && bus.smiRespEofc != 8'd0) state_nxt = DONE;
            end
            DONE: begin
                bus.doneValid    = 1'b1;
                bus.doneStatusOk = status_ok;
                if (!bus.doneStop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_smi_mem_lib_read_burst_single64.sv
// Directed bench for the single SMI read burst engine: table of burst scenarios plus
// hand-written reset and stall sequences.
module tb_smi_mem_lib_read_burst_single64;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    smi_mem_lib_read_burst_single64_if bus();
    smi_mem_lib_read_burst_single64 dut (.clk(clk), .srst(srst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] len;
        logic [63:0] addr;
        logic [7:0]  opts;
        logic [7:0]  hstat;
        bit          hdr_only;
        int          nflits;
        int          stall;
        int          reqstop;
        int          exp_words;
        bit          exp_ok;
        int          exp_req;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.paramsValid    = 1'b0;
        bus.paramBurstAddr = 64'd0;
        bus.paramBurstLen  = 16'd0;
        bus.paramBurstOpts = 8'd0;
        bus.readStop       = 1'b0;
        bus.doneStop       = 1'b0;
        bus.smiReqStop     = 1'b0;
        bus.smiRespValid   = 1'b0;
        bus.smiRespEofc    = 8'd0;
        bus.smiRespData    = 64'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_params_stop"}, bus.paramsStop, 1'b0);
        check({tag, "_read_valid"}, bus.readValid, 1'b0);
        check({tag, "_done_valid"}, bus.doneValid, 1'b0);
        check({tag, "_done_ok"}, bus.doneStatusOk, 1'b0);
        check({tag, "_req_valid"}, bus.smiReqValid, 1'b0);
        check({tag, "_resp_stop"}, bus.smiRespStop, 1'b1);
    endtask

    task automatic run_burst(input int k);
        vec_t        v;
        logic [63:0] rdata[$];
        logic [7:0]  reofc[$];
        logic [63:0] words[$];
        logic [63:0] reqd[$];
        logic [7:0]  reqe[$];
        logic [63:0] exp_hdr, exp_addr, exp_word;
        int ri, done_cyc, stall_bad, stall_hits, hold_bad, word_bad;
        bit done_seen, done_ok;
        v = vecs[k];
        ri = 0; done_cyc = -1; stall_bad = 0; stall_hits = 0; hold_bad = 0; word_bad = 0;
        done_seen = 1'b0; done_ok = 1'b0;
        exp_hdr  = {24'd0, v.opts, v.len[12:0], 3'b000, 8'd0, 8'h02};
        exp_addr = {v.addr[63:3], 3'b000};
        if (v.exp_req != 0) begin
            rdata.push_back({48'd0, v.hstat, 8'd0});
            reofc.push_back(v.hdr_only ? 8'd8 : 8'd0);
            for (int i = 0; i < v.nflits; i++) begin
                rdata.push_back(64'hD000_0000_0000_0000 | (64'(k) << 16) | 64'(i));
                reofc.push_back((i == v.nflits - 1) ? 8'd8 : 8'd0);
            end
        end

        @(negedge clk);
        #1 check($sformatf("v%0d_idle_params_stop", k), bus.paramsStop, 1'b0);
        bus.paramsValid    = 1'b1;
        bus.paramBurstAddr = v.addr;
        bus.paramBurstLen  = v.len;
        bus.paramBurstOpts = v.opts;
        @(posedge clk);
        @(negedge clk);
        bus.paramsValid = 1'b0;

        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            bus.smiReqStop = (cyc < v.reqstop);
            bus.readStop   = (v.stall > 0 && cyc >= 3 && cyc < 3 + v.stall);
            if (ri < rdata.size()) begin
                bus.smiRespValid = 1'b1;
                bus.smiRespData  = rdata[ri];
                bus.smiRespEofc  = reofc[ri];
            end else begin
                bus.smiRespValid = 1'b0;
                bus.smiRespData  = 64'd0;
                bus.smiRespEofc  = 8'd0;
            end
            #1;
            if (cyc < v.reqstop &&
                (bus.smiReqValid !== 1'b1 || bus.smiReqData !== exp_hdr || bus.smiReqEofc !== 8'd0))
                hold_bad++;
            if (bus.smiReqValid && !bus.smiReqStop) begin
                reqd.push_back(bus.smiReqData);
                reqe.push_back(bus.smiReqEofc);
            end
            if (bus.readStop && bus.readValid) begin
                stall_hits++;
                if (!bus.smiRespStop) stall_bad++;
            end
            if (bus.readValid && !bus.readStop) words.push_back(bus.readData);
            if (bus.smiRespValid && !bus.smiRespStop) ri++;
            if (bus.doneValid && !bus.doneStop) begin
                done_seen = 1'b1;
                done_ok   = bus.doneStatusOk;
                done_cyc  = cyc;
            end
            @(negedge clk);
        end
        idle_inputs();

        check($sformatf("v%0d_done_seen", k), done_seen, 1'b1);
        check($sformatf("v%0d_done_ok", k), done_ok, v.exp_ok);
        check($sformatf("v%0d_req_count", k), reqd.size(), v.exp_req);
        if (v.exp_req == 2 && reqd.size() == 2) begin
            check($sformatf("v%0d_req_hdr_data", k), reqd[0], exp_hdr);
            check($sformatf("v%0d_req_hdr_eofc", k), reqe[0], 8'd0);
            check($sformatf("v%0d_req_addr_data", k), reqd[1], exp_addr);
            check($sformatf("v%0d_req_addr_eofc", k), reqe[1], 8'd8);
        end
        check($sformatf("v%0d_word_count", k), words.size(), v.exp_words);
        foreach (words[i]) begin
            exp_word = 64'hD000_0000_0000_0000 | (64'(k) << 16) | 64'(i);
            if (words[i] !== exp_word) word_bad++;
        end
        check($sformatf("v%0d_word_order", k), word_bad, 0);
        check($sformatf("v%0d_resp_consumed", k), ri, rdata.size());
        check($sformatf("v%0d_stall_hits", k), stall_hits, v.stall);
        check($sformatf("v%0d_stall_backpressure", k), stall_bad, 0);
        check($sformatf("v%0d_req_hold", k), hold_bad, 0);
        if (v.exp_req == 0)
            check($sformatf("v%0d_fast_done", k), (done_cyc >= 0 && done_cyc <= 1), 1'b1);
        #1 check($sformatf("v%0d_back_idle", k), bus.paramsStop, 1'b0);
    endtask

    initial begin
        int bad;
        //            len       addr                  opts   hstat  hdr nfl stall rqs words ok  req
        vecs[0]  = '{16'd4,    64'h1007,             8'h00, 8'h00, 1'b0, 4,  0,  0,  4, 1'b1, 2};
        vecs[1]  = '{16'd2,    64'h2000,             8'h5A, 8'h00, 1'b0, 2,  5,  0,  2, 1'b1, 2};
        vecs[2]  = '{16'd3,    64'hFFFF_0000_0000_0013, 8'h01, 8'h05, 1'b0, 3, 0, 0,  3, 1'b0, 2};
        vecs[3]  = '{16'd4,    64'h4000,             8'h00, 8'h00, 1'b0, 2,  0,  0,  2, 1'b0, 2};
        vecs[4]  = '{16'd2,    64'h5008,             8'h00, 8'h00, 1'b0, 4,  0,  0,  2, 1'b0, 2};
        vecs[5]  = '{16'd0,    64'h6000,             8'h00, 8'h00, 1'b0, 0,  0,  0,  0, 1'b0, 0};
        vecs[6]  = '{16'd513,  64'h7000,             8'h00, 8'h00, 1'b0, 0,  0,  0,  0, 1'b0, 0};
        vecs[7]  = '{16'd1,    64'h8001,             8'hC3, 8'h00, 1'b0, 1,  0,  3,  1, 1'b1, 2};
        vecs[8]  = '{16'd512,  64'h9000,             8'h00, 8'h00, 1'b0, 512, 0, 0, 512, 1'b1, 2};
        vecs[9]  = '{16'd3,    64'hA000,             8'h00, 8'h00, 1'b1, 0,  0,  0,  0, 1'b0, 2};
        vecs[10] = '{16'h2004, 64'hB000,             8'h00, 8'h00, 1'b0, 0,  0,  0,  0, 1'b0, 0};

        idle_inputs();
        srst = 1'b1;
        #12 check_reset_outputs("reset");
        @(negedge clk);
        srst = 1'b0;

        for (int k = 0; k < 11; k++) run_burst(k);

        // Reset asserted mid-cycle while streaming data must abandon the burst at once.
        @(negedge clk);
        bus.paramsValid    = 1'b1;
        bus.paramBurstAddr = 64'h3000;
        bus.paramBurstLen  = 16'd4;
        @(posedge clk);
        @(negedge clk);
        bus.paramsValid  = 1'b0;
        bus.smiRespValid = 1'b1;
        bus.smiRespData  = 64'd0;
        bus.smiRespEofc  = 8'd0;
        repeat (3) @(negedge clk);
        bus.smiRespData = 64'hBEEF;
        #1 check("rst_pre_read_valid", bus.readValid, 1'b1);
        check("rst_pre_read_data", bus.readData, 64'hBEEF);
        #2 srst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        srst = 1'b0;
        idle_inputs();
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            #1 if (bus.doneValid !== 1'b0 || bus.paramsStop !== 1'b0 || bus.smiReqValid !== 1'b0) bad++;
        end
        check("rst_post_quiet", bad, 0);

        run_burst(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/smi_mem_lib_read_burst_single64.md
SMI_MEM_LIB_READ_BURST_SINGLE64 -- requirements
Module: smi_mem_lib_read_burst_single64

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; srst in 1, asynchronous active-high reset.
REQ-002 SHALL have params ports: paramsValid in 1; paramBurstAddr in 64 (byte address); paramBurstLen in 16 (64-bit words); paramBurstOpts in 8; paramsStop out 1.
REQ-003 SHALL have read data ports: readValid out 1; readData out 64; readStop in 1.
REQ-004 SHALL have done ports: doneValid out 1; doneStatusOk out 1; doneStop in 1.
REQ-005 SHALL have SMI request ports: smiReqValid out 1; smiReqEofc out 8; smiReqData out 64; smiReqStop in 1.
REQ-006 SHALL have SMI response ports: smiRespValid in 1; smiRespEofc in 8; smiRespData in 64; smiRespStop out 1.
REQ-007 SHALL transfer on any SELF link only in cycles where valid=1 and stop=0 at the rising clk edge.

Function
REQ-008 SHALL run FSM states IDLE, REQ_HDR, REQ_ADDR, RESP_HDR, RESP_DATA, RESP_DRAIN, DONE.
REQ-009 IDLE: paramsStop=0; on params transfer, capture addr, len[12:0], opts; go REQ_HDR, or DONE with status 0 if len[12:0]==0 or len>512 (no SMI traffic).
REQ-010 SHALL force captured address to 8-byte alignment (bits [2:0]=0) and byte length = len[12:0]<<3.
REQ-011 REQ_HDR: smiReqValid=1, smiReqEofc=0, smiReqData = {24'd0, opts, byteLen[15:0], 8'd0, 8'h02}; on transfer go REQ_ADDR.
REQ-012 REQ_ADDR: smiReqValid=1, smiReqEofc=8, smiReqData = aligned address; on transfer go RESP_HDR.
REQ-013 RESP_HDR: smiRespStop=0; on transfer latch statusOk = (data[15:8]==0); if eofc!=0 (header-only frame) go DONE with statusOk=0, else go RESP_DATA with word counter = len.
REQ-014 RESP_DATA: readValid=smiRespValid, readData=smiRespData, smiRespStop=readStop (combinational pass-through, zero latency); each transfer decrements counter.
REQ-015 RESP_DATA: transfer with eofc!=0 before counter==1 SHALL end burst, clear statusOk, go DONE (short response).
REQ-016 RESP_DATA: transfer with counter==1 and eofc==0 SHALL clear statusOk and go RESP_DRAIN; counter==1 and eofc!=0 goes DONE.
REQ-017 RESP_DRAIN: readValid=0, smiRespStop=0; discard flits until one with eofc!=0; then DONE.
REQ-018 DONE: doneValid=1, doneStatusOk=latched status; on transfer go IDLE; paramsStop=1 in all non-IDLE states.
REQ-019 SHALL emit exactly min(len, flits received) data words per burst, in arrival order, with no gaps introduced by the block.
REQ-020 smiRespStop SHALL be 1 in IDLE, REQ_HDR, REQ_ADDR, DONE; smiReqValid SHALL be 0 outside REQ_HDR/REQ_ADDR.
REQ-021 SHALL hold smiReqData/smiReqEofc stable while smiReqValid=1 and smiReqStop=1.
REQ-022 Word counter SHALL be 13 bits; address/length registers need not reset.

Reset
REQ-023 srst assertion SHALL asynchronously force IDLE; outputs: paramsStop=0, readValid=0, doneValid=0, doneStatusOk=0, smiReqValid=0, smiRespStop=1.
REQ-024 srst mid-burst SHALL abandon the burst with no done output; first post-reset action is waiting for new params.

Verification
REQ-025 len=4, addr=0x1007, OK header, 4 data flits (last eofc=8) -> request flits 0x...0020..02 / 0x1000, 4 words out in order, done statusOk=1.
REQ-026 len=2, readStop held 1 for 5 cycles mid-burst -> smiRespStop=1 those cycles, no words lost or duplicated, done statusOk=1.
REQ-027 len=3, response header status 0x05 with 3 data flits -> 3 words out, done statusOk=0.
REQ-028 len=4, response ends after 2 data flits (eofc=8) -> 2 words out, done statusOk=0; len=2 with 4 flits -> 2 words out, 2 drained, statusOk=0.
REQ-029 len=0 and len=513 -> no SMI request, done statusOk=0 within 2 cycles.
REQ-030 srst asserted in RESP_DATA, smiReqStop=1 during REQ_HDR -> immediate IDLE values per REQ-023; next len=1 burst completes with statusOk=1.
